// File: rtl/count_capture.sv
// Downstream monitor for a 4-bit up-counter: checks the count sequence and flags wraps.
// It also holds a saturating wrap count and hands out count/wrap snapshots over valid/ready.
module count_capture (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cin,
  input  logic       up,
  input  logic [3:0] target,
  input  logic       cap_req,
  input  logic       cap_ready,
  input  logic       clr_sticky,
  output logic       cap_valid,
  output logic [3:0] cap_data,
  output logic [7:0] cap_wraps,
  output logic       match,
  output logic       wrap,
  output logic       err,
  output logic       ovf
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [3:0] r_cin_q;
  logic       r_up_q;
  logic       r_hist_v;
  logic [7:0] r_wrap_cnt;
  logic       r_match;
  logic       r_wrap;
  logic       r_err;
  logic       r_ovf;
  logic [0:0] r_state;
  logic [3:0] r_cap_data;
  logic [7:0] r_cap_wraps;

  logic [3:0] w_exp;
  logic       w_viol;
  logic       w_wrap_ev;
  logic       w_clr_ev;
  logic [7:0] w_wrap_cnt_nxt;
  logic       w_err_nxt;
  logic       w_ovf_nxt;
  logic       w_load;
  logic       w_drop;
  logic [0:0] w_state_nxt;

  // Sequence check, wrap detection and saturating wrap counter next-state.
  always_comb begin
    w_exp          = 4'd0;
    w_viol         = 1'b0;
    w_wrap_ev      = 1'b0;
    w_clr_ev       = 1'b0;
    w_wrap_cnt_nxt = r_wrap_cnt;
    w_err_nxt      = r_err;

    // The counter clears when up is low, so the expected value is 0, not a hold.
    if (r_up_q) begin
      w_exp = r_cin_q + 4'd1;
    end else begin
      w_exp = 4'd0;
    end

    w_viol    = r_hist_v && (cin != w_exp);
    w_wrap_ev = r_hist_v && r_up_q && (r_cin_q == 4'd15) && (cin == 4'd0);
    w_clr_ev  = r_hist_v && !r_up_q;

    if (w_clr_ev) begin
      w_wrap_cnt_nxt = 8'd0;
    end else if (w_wrap_ev && (r_wrap_cnt != 8'd255)) begin
      w_wrap_cnt_nxt = r_wrap_cnt + 8'd1;
    end else begin
      w_wrap_cnt_nxt = r_wrap_cnt;
    end

    if (w_viol) begin
      w_err_nxt = 1'b1;
    end else if (clr_sticky) begin
      w_err_nxt = 1'b0;
    end else begin
      w_err_nxt = r_err;
    end
  end

  // Capture handshake: decide load / drop / release for the snapshot slot.
  always_comb begin
    w_load      = 1'b0;
    w_drop      = 1'b0;
    w_state_nxt = r_state;
    w_ovf_nxt   = r_ovf;

    case (r_state)
      ST_EMPTY: begin
        if (cap_req) begin
          w_load      = 1'b1;
          w_state_nxt = ST_FULL;
        end else begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (cap_ready && cap_req) begin
          w_load      = 1'b1;
          w_state_nxt = ST_FULL;
        end else if (cap_ready) begin
          w_state_nxt = ST_EMPTY;
        end else if (cap_req) begin
          w_drop      = 1'b1;
          w_state_nxt = ST_FULL;
        end else begin
          w_state_nxt = ST_FULL;
        end
      end
      default: begin
        w_state_nxt = ST_EMPTY;
      end
    endcase

    if (w_drop) begin
      w_ovf_nxt = 1'b1;
    end else if (clr_sticky) begin
      w_ovf_nxt = 1'b0;
    end else begin
      w_ovf_nxt = r_ovf;
    end
  end

  // State registers; reset is synchronous and active-low.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cin_q     <= 4'd0;
      r_up_q      <= 1'b0;
      r_hist_v    <= 1'b0;
      r_wrap_cnt  <= 8'd0;
      r_match     <= 1'b0;
      r_wrap      <= 1'b0;
      r_err       <= 1'b0;
      r_ovf       <= 1'b0;
      r_state     <= ST_EMPTY;
      r_cap_data  <= 4'd0;
      r_cap_wraps <= 8'd0;
    end else begin
      r_cin_q    <= cin;
      r_up_q     <= up;
      r_hist_v   <= 1'b1;
      r_wrap_cnt <= w_wrap_cnt_nxt;
      r_match    <= (cin == target);
      r_wrap     <= w_wrap_ev;
      r_err      <= w_err_nxt;
      r_ovf      <= w_ovf_nxt;
      r_state    <= w_state_nxt;
      // Snapshot takes the wrap count as it stood before this edge's update.
      if (w_load) begin
        r_cap_data  <= cin;
        r_cap_wraps <= r_wrap_cnt;
      end else begin
        r_cap_data  <= r_cap_data;
        r_cap_wraps <= r_cap_wraps;
      end
    end
  end

  assign cap_valid = (r_state == ST_FULL);
  assign cap_data  = r_cap_data;
  assign cap_wraps = r_cap_wraps;
  assign match     = r_match;
  assign wrap      = r_wrap;
  assign err       = r_err;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_count_capture.sv
// Directed bench for count_capture: a behavioural counter drives cin, with
// fault injection, clear path, capture handshake, saturation and reset checks.
module tb_count_capture;

  logic       clk;
  logic       reset;
  logic [3:0] cin;
  logic       up;
  logic [3:0] target;
  logic       cap_req;
  logic       cap_ready;
  logic       clr_sticky;
  logic       cap_valid;
  logic [3:0] cap_data;
  logic [7:0] cap_wraps;
  logic       match;
  logic       wrap;
  logic       err;
  logic       ovf;

  logic [3:0] cnt;
  int         n_tests;
  int         n_fail;

  count_capture dut (
    .clk        (clk),
    .reset      (reset),
    .cin        (cin),
    .up         (up),
    .target     (target),
    .cap_req    (cap_req),
    .cap_ready  (cap_ready),
    .clr_sticky (clr_sticky),
    .cap_valid  (cap_valid),
    .cap_data   (cap_data),
    .cap_wraps  (cap_wraps),
    .match      (match),
    .wrap       (wrap),
    .err        (err),
    .ovf        (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock; the behavioural counter follows up/reset on the same edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (!reset)  cnt = 4'd0;
    else if (up) cnt = cnt + 4'd1;
    else         cnt = 4'd0;
    cin = cnt;
  endtask

  task automatic run_to(input logic [3:0] v);
    for (int k = 0; k < 32 && cnt != v; k++) tick();
  endtask

  int nw;
  int nm;
  int w_first;
  int w_last;

  initial begin
    n_tests = 0; n_fail = 0;
    reset = 1'b0; cin = 4'd0; up = 1'b0; target = 4'd0;
    cap_req = 1'b0; cap_ready = 1'b0; clr_sticky = 1'b0; cnt = 4'd0;

    // Reset hold with random inputs
    for (int i = 0; i < 3; i++) begin
      cin = 4'($urandom_range(0, 15)); up = 1'($urandom_range(0, 1));
      target = 4'($urandom_range(0, 15)); cap_req = 1'($urandom_range(0, 1));
      cap_ready = 1'($urandom_range(0, 1)); clr_sticky = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      check_eq("reset_outs", {cap_valid, match, wrap, err, ovf, cap_data, cap_wraps}, 32'd0);
    end
    reset = 1'b1; cnt = 4'd0; cin = 4'd0; up = 1'b1; target = 4'd5;
    cap_req = 1'b0; cap_ready = 1'b0; clr_sticky = 1'b0;

    // Clean counting, 40 cycles
    nw = 0; nm = 0; w_first = -1; w_last = -1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (i == 0) check_eq("err_after_release", err, 1'b0);
      if (wrap) begin
        nw++;
        if (w_first < 0) w_first = i;
        w_last = i;
      end
      if (match) nm++;
    end
    check_eq("wrap_pulses", nw, 2);
    check_eq("wrap_first", w_first, 16);
    check_eq("wrap_spacing", w_last - w_first, 16);
    check_eq("match_pulses", nm, 3);
    check_eq("wrap_cnt_2", dut.r_wrap_cnt, 8'd2);
    check_eq("err_clean", err, 1'b0);

    // Fault injection 3 -> 5
    run_to(4'd3);
    tick();
    cnt = 4'd5; cin = 4'd5;
    tick();
    check_eq("err_set", err, 1'b1);
    tick();
    check_eq("err_held", err, 1'b1);
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    check_eq("err_cleared", err, 1'b0);
    // Violation and clear on the same edge: set wins
    cnt = 4'd12; cin = 4'd12; clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    check_eq("err_set_wins", err, 1'b1);
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    check_eq("err_cleared2", err, 1'b0);

    // Clear path at 15 -> 0 with up low: no wrap
    run_to(4'd15);
    check_eq("wrap_cnt_3", dut.r_wrap_cnt, 8'd3);
    up = 1'b0;
    tick();
    up = 1'b1;
    check_eq("cin_cleared", cin, 4'd0);
    check_eq("wrap_cnt_hold", dut.r_wrap_cnt, 8'd3);
    tick();
    check_eq("clr_no_wrap", wrap, 1'b0);
    check_eq("clr_wrap_cnt", dut.r_wrap_cnt, 8'd0);
    check_eq("clr_err", err, 1'b0);

    // Capture handshake
    run_to(4'd9);
    cap_req = 1'b1;
    tick();
    cap_req = 1'b0;
    check_eq("cap_valid_1", cap_valid, 1'b1);
    check_eq("cap_data_9", cap_data, 4'd9);
    check_eq("cap_wraps_0", cap_wraps, 8'd0);
    cap_req = 1'b1;
    tick();
    cap_req = 1'b0;
    check_eq("ovf_set", ovf, 1'b1);
    check_eq("cap_data_held", cap_data, 4'd9);
    check_eq("cap_valid_held", cap_valid, 1'b1);
    run_to(4'd12);
    check_eq("cap_data_stable", cap_data, 4'd9);
    cap_req = 1'b1; cap_ready = 1'b1;
    tick();
    cap_req = 1'b0;
    check_eq("cap_data_12", cap_data, 4'd12);
    check_eq("cap_valid_reload", cap_valid, 1'b1);
    tick();
    cap_ready = 1'b0;
    check_eq("cap_valid_drain", cap_valid, 1'b0);
    check_eq("cap_data_after", cap_data, 4'd12);
    check_eq("ovf_sticky", ovf, 1'b1);
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    check_eq("ovf_cleared", ovf, 1'b0);

    // 300 wraps then saturation
    nw = 0;
    for (int i = 0; i < 300 * 16; i++) begin
      tick();
      if (wrap) nw++;
    end
    check_eq("wrap_300", nw, 300);
    check_eq("wrap_cnt_sat", dut.r_wrap_cnt, 8'd255);
    check_eq("err_long", err, 1'b0);
    cap_req = 1'b1;
    tick();
    cap_req = 1'b0;
    check_eq("cap_valid_sat", cap_valid, 1'b1);
    check_eq("cap_wraps_255", cap_wraps, 8'd255);

    // Reset while FULL
    reset = 1'b0;
    tick();
    check_eq("rst_cap_valid", cap_valid, 1'b0);
    check_eq("rst_outs", {cap_valid, match, wrap, err, ovf, cap_data, cap_wraps}, 32'd0);
    check_eq("rst_wrap_cnt", dut.r_wrap_cnt, 8'd0);
    reset = 1'b1;
    tick();
    check_eq("err_after_rst2", err, 1'b0);
    tick();
    check_eq("err_count_rst2", err, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/count_capture.md
# count_capture

Downstream monitor for the 4-bit up-counter. It samples the counter's `cout` bus and `up` enable every clock and checks that the count follows the counter's rules. It produces a match strobe against a programmable target and a wrap strobe, and keeps a saturating wrap count. On request it captures a snapshot (count + wraps) and hands it off over a valid/ready interface.

## Interface
- No parameters; widths fixed: count 4 bits, wrap counter 8 bits.
- `clk` in 1: single clock, all logic on posedge.
- `reset` in 1: synchronous, active-low; when 0 at a posedge, all state clears.
- `cin` in 4: counter value (connected to counter `cout`).
- `up` in 1: same `up` signal that drives the counter.
- `target` in 4: compare value for `match`.
- `cap_req` in 1: capture request, sampled each posedge.
- `cap_ready` in 1: consumer accepts snapshot.
- `clr_sticky` in 1: clears `err` and `ovf`.
- `cap_valid` out 1: snapshot held on `cap_data`/`cap_wraps`.
- `cap_data` out 4: captured count.
- `cap_wraps` out 8: captured wrap count.
- `match` out 1: registered, `cin == target`.
- `wrap` out 1: one-cycle pulse on a legal 15→0 increment.
- `err` out 1: sticky sequence-violation flag.
- `ovf` out 1: sticky dropped-capture flag.

## Operation
- History registers: `cin_q`, `up_q` and `hist_v` sample `cin`, `up` and 1 at every non-reset posedge. `hist_v` is 0 for the first cycle after reset.
- Expected count: if `up_q` = 1, then (`cin_q` + 1) mod 16; otherwise 0. This matches the counter: `up` = 0 clears the count and `up` = 1 increments it, with the counter register updating on the same edge that loads `up_q`.
- Error: at a posedge with `hist_v` = 1 and `cin` ≠ expected, `err` sets on the next cycle and stays set. `clr_sticky` = 1 clears it. If a violation and `clr_sticky` occur at the same edge, set wins.
- Wrap: `hist_v` & `up_q` & `cin_q` = 15 & `cin` = 0 gives a `wrap` pulse on the next cycle. `wrap_cnt` increments in the same cycle, saturating at 255.
- Clear: `hist_v` & !`up_q` clears `wrap_cnt` to 0. No `wrap` pulse is produced.
- `match` is registered: `match` = (`cin` == `target`), sampled at every posedge, including when `hist_v` = 0.
- Capture handshake, two states:
  - EMPTY (`cap_valid` = 0): `cap_req` = 1 latches `cap_data` ← `cin` and `cap_wraps` ← `wrap_cnt` (pre-update value at that edge), then moves to FULL.
  - FULL (`cap_valid` = 1): data is held stable.
    - `cap_ready` = 1 and `cap_req` = 0: return to EMPTY.
    - `cap_ready` = 1 and `cap_req` = 1: reload with new data, stay FULL.
    - `cap_ready` = 0 and `cap_req` = 1: request dropped, `ovf` sets (sticky, cleared by `clr_sticky`, set wins).
- Mid-operation reset: pending snapshot discarded, history invalidated, all flags cleared.

## Timing
- Reset values: `cap_valid` 0, `cap_data` 0, `cap_wraps` 0, `match` 0, `wrap` 0, `err` 0, `ovf` 0, `wrap_cnt` 0, `hist_v` 0.
- Latency from edge to output:
  - `cin` → `match`: 1 cycle.
  - Offending `cin` → `err`: 1 cycle.
  - `cap_req` → `cap_valid`: 1 cycle.
  - 15→0 transition visible on `cin` → `wrap`: 1 cycle.
- Throughput: one capture per cycle while `cap_ready` is held high.
- `cap_data`/`cap_wraps` may change only at an edge where EMPTY + `cap_req`, or FULL + `cap_ready` + `cap_req`.
- `up` and `cin` are assumed synchronous to `clk`; no CDC logic.

## Test plan
- Reset hold: `reset` = 0 for 3 cycles with random inputs → all outputs 0; `err` stays 0 on the first cycle after release.
- Clean counting: drive a real counter with `up` = 1 for 40 cycles, `target` = 5 → `wrap` pulses at 16-cycle spacing, `wrap_cnt` = 2 after 2 wraps, `match` high for one cycle every 16, `err` = 0.
- Fault injection: force `cin` 3→5 with `up` = 1 → `err` = 1 next cycle and held; `clr_sticky` pulse → `err` = 0.
- Clear path: `up` = 0 for one cycle mid-count with `wrap_cnt` = 3 → `cin` = 0, `wrap_cnt` = 0, no `wrap` pulse, `err` = 0.
- Handshake: `cap_req` at `cin` = 9 with `cap_ready` = 0 → `cap_valid` = 1, `cap_data` = 9. Second `cap_req` → `ovf` = 1, data still 9. Raise `cap_ready` together with `cap_req` at `cin` = 12 → `cap_data` = 12, `cap_valid` stays 1. `cap_ready` alone → `cap_valid` = 0.
- Saturation/reset: 300 wraps → `cap_wraps` = 255. Assert `reset` while FULL → `cap_valid` = 0 next cycle.
